// File: rtl/jt51_lin2log.sv
// jt51_lin2log: iterative linear-to-log2 converter for 14-bit signed operator samples.
// Define JT51_LIN2LOG_INTERP_EN to interpolate linearly between log2 table entries.
module jt51_lin2log (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [13:0] lin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic        out_zero,
  output logic [3:0]  out_exp,
  output logic [7:0]  out_frac
);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    LUT,
`ifdef JT51_LIN2LOG_INTERP_EN
    INTERP,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [13:0] lin_q;
  logic [13:0] mag;
  logic [3:0]  e;
  logic        sign;
  logic [13:0] abs_lin;
  logic [4:0]  idx;
  logic [7:0]  t_cur;

`ifdef JT51_LIN2LOG_INTERP_EN
  logic [7:0]  t_lo;
  logic [8:0]  t_hi;
  logic [2:0]  r;
  logic [8:0]  t_next;
  logic [8:0]  diff;
`endif

  // T[k] = round(256*log2(1+k/32)) for k=0..31; T[32]=256 is handled separately
  function automatic logic [7:0] log_tbl(input logic [4:0] k);
    case (k)
      5'd0:  log_tbl = 8'd0;    5'd1:  log_tbl = 8'd11;
      5'd2:  log_tbl = 8'd22;   5'd3:  log_tbl = 8'd33;
      5'd4:  log_tbl = 8'd44;   5'd5:  log_tbl = 8'd54;
      5'd6:  log_tbl = 8'd63;   5'd7:  log_tbl = 8'd73;
      5'd8:  log_tbl = 8'd82;   5'd9:  log_tbl = 8'd92;
      5'd10: log_tbl = 8'd100;  5'd11: log_tbl = 8'd109;
      5'd12: log_tbl = 8'd118;  5'd13: log_tbl = 8'd126;
      5'd14: log_tbl = 8'd134;  5'd15: log_tbl = 8'd142;
      5'd16: log_tbl = 8'd150;  5'd17: log_tbl = 8'd157;
      5'd18: log_tbl = 8'd165;  5'd19: log_tbl = 8'd172;
      5'd20: log_tbl = 8'd179;  5'd21: log_tbl = 8'd186;
      5'd22: log_tbl = 8'd193;  5'd23: log_tbl = 8'd200;
      5'd24: log_tbl = 8'd207;  5'd25: log_tbl = 8'd213;
      5'd26: log_tbl = 8'd220;  5'd27: log_tbl = 8'd226;
      5'd28: log_tbl = 8'd232;  5'd29: log_tbl = 8'd238;
      5'd30: log_tbl = 8'd244;  default: log_tbl = 8'd250;
    endcase
  endfunction

  // Two's-complement magnitude; -8192 naturally maps to 0x2000
  assign abs_lin = lin_q[13] ? (~lin_q + 14'd1) : lin_q;
  assign idx     = mag[12:8];
  assign t_cur   = log_tbl(idx);

`ifdef JT51_LIN2LOG_INTERP_EN
  assign t_next = (idx == 5'd31) ? 9'd256 : {1'b0, log_tbl(idx + 5'd1)};
  assign diff   = t_hi - {1'b0, t_lo};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_exp   <= 4'd0;
      out_frac  <= 8'd0;
      lin_q     <= 14'd0;
      mag       <= 14'd0;
      e         <= 4'd0;
      sign      <= 1'b0;
`ifdef JT51_LIN2LOG_INTERP_EN
      t_lo      <= 8'd0;
      t_hi      <= 9'd0;
      r         <= 3'd0;
`endif
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lin_q    <= lin;
            in_ready <= 1'b0;
            state    <= ABS;
          end
        end
        ABS: begin
          mag  <= abs_lin;
          sign <= lin_q[13];
          e    <= 4'd13;
          if (abs_lin == 14'd0) begin
            out_zero  <= 1'b1;
            out_sign  <= 1'b0;
            out_exp   <= 4'd0;
            out_frac  <= 8'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= NORM;
          end
        end
        // One shift per enabled cycle until the leading one reaches bit 13
        NORM: begin
          if (mag[13]) begin
            state <= LUT;
          end else begin
            mag <= {mag[12:0], 1'b0};
            e   <= e - 4'd1;
          end
        end
`ifdef JT51_LIN2LOG_INTERP_EN
        LUT: begin
          t_lo  <= t_cur;
          t_hi  <= t_next;
          r     <= mag[7:5];
          state <= INTERP;
        end
        INTERP: begin
          out_frac  <= t_lo + 8'((12'(diff) * 12'(r)) >> 3);
          out_exp   <= e;
          out_sign  <= sign;
          out_zero  <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`else
        LUT: begin
          out_frac  <= t_cur;
          out_exp   <= e;
          out_sign  <= sign;
          out_zero  <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_lin2log.sv
// Self-checking bench for jt51_lin2log: directed corner cases, back-pressure, cen gating,
// mid-conversion reset and a random sweep against a log2 reference model.
module tb_jt51_lin2log;

`ifdef JT51_LIN2LOG_INTERP_EN
  localparam int LX = 4;
  localparam int FRAC1FFF = 255;
`else
  localparam int LX = 3;
  localparam int FRAC1FFF = 250;
`endif

  typedef struct {
    logic       sign;
    logic       zero;
    logic [3:0] e;
    logic [7:0] f;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [13:0] lin = 14'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_sign, out_zero;
  logic [3:0]  out_exp;
  logic [7:0]  out_frac;

  int   testsRun = 0;
  int   failCount = 0;
  int   cenDiv = 1;
  int   cenCnt = 0;
  int   measLat, measCyc;
  int   tbl[0:32];
  exp_t sb[$];

  jt51_lin2log dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .lin(lin), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_zero(out_zero), .out_exp(out_exp), .out_frac(out_frac)
  );

  always #5 clk = ~clk;

  // cen pattern changes just after each posedge so it is stable at the next edge
  always @(posedge clk) begin
    #2;
    cenCnt++;
    cen = (cenDiv <= 1) || (cenCnt % cenDiv == 0);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic timeoutFail(input string tag);
    testsRun++;
    failCount++;
    $display("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  function automatic exp_t mk(input logic s, input logic z, input int e, input int f, input int lat);
    exp_t x;
    x.sign = s; x.zero = z; x.e = 4'(e); x.f = 8'(f); x.lat = lat;
    return x;
  endfunction

  function automatic exp_t refModel(input logic [13:0] v);
    int sv, a, msb, m, i, r, f;
    sv = v[13] ? int'(v) - 16384 : int'(v);
    a = (sv < 0) ? -sv : sv;
    if (a == 0) return mk(1'b0, 1'b1, 0, 0, 1);
    msb = 0;
    for (int b = 0; b < 14; b++) if (a >= (1 << b)) msb = b;
    m = a << (13 - msb);
    i = (m >> 8) & 31;
    r = (m >> 5) & 7;
`ifdef JT51_LIN2LOG_INTERP_EN
    f = tbl[i] + ((tbl[i+1] - tbl[i]) * r) / 8;
`else
    f = tbl[i];
`endif
    return mk(sv < 0, 1'b0, msb, f, 13 - msb + LX);
  endfunction

  task automatic applyStimulus(input logic [13:0] v, input exp_t x);
    int guard = 0;
    sb.push_back(x);
    @(negedge clk);
    lin = v;
    in_valid = 1'b1;
    while (!(in_ready && cen) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) timeoutFail("accept");
    @(negedge clk);
    in_valid = 1'b0;
    lin = 14'($urandom);
  endtask

  task automatic waitResult();
    int guard = 0;
    measLat = 0;
    measCyc = 0;
    while (!out_valid && guard < 400) begin
      if (cen) measLat++;
      measCyc++;
      @(negedge clk);
      guard++;
    end
    if (!out_valid) timeoutFail("result");
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      timeoutFail("scoreboardEmpty");
      return;
    end
    x = sb.pop_front();
    compare("outValid", out_valid, 1);
    compare("outSign", out_sign, x.sign);
    compare("outZero", out_zero, x.zero);
    compare("outExp", out_exp, x.e);
    compare("outFrac", out_frac, x.f);
    compare("latencyCen", measLat, x.lat);
    compare("latencyCycles", measCyc, x.lat * ((cenDiv <= 1) ? 1 : cenDiv));
  endtask

  task automatic consume();
    int guard = 0;
    out_ready = 1'b1;
    while (!cen && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    compare("outValidDrop", out_valid, 0);
    compare("inReadyBack", in_ready, 1);
  endtask

  task automatic runOne(input logic [13:0] v, input exp_t x);
    applyStimulus(v, x);
    waitResult();
    checkOutput();
    consume();
  endtask

  initial begin
    logic [3:0] snapExp;
    logic [7:0] snapFrac;
    logic       stable;
    logic [13:0] v;

    for (int k = 0; k <= 32; k++)
      tbl[k] = $rtoi($floor(256.0 * $ln(1.0 + k / 32.0) / $ln(2.0) + 0.5));

    repeat (3) @(negedge clk);
    compare("rstInReady", in_ready, 1);
    compare("rstOutValid", out_valid, 0);
    compare("rstOutExp", out_exp, 0);
    compare("rstOutFrac", out_frac, 0);
    rst_n = 1'b1;

    runOne(14'h2000, mk(1'b1, 1'b0, 13, 0, LX));
    runOne(14'h0001, mk(1'b0, 1'b0, 0, 0, 13 + LX));
    runOne(14'h1FFF, mk(1'b0, 1'b0, 12, FRAC1FFF, 1 + LX));
    runOne(14'd3072, mk(1'b0, 1'b0, 11, 150, 2 + LX));
    runOne(14'h0000, mk(1'b0, 1'b1, 0, 0, 1));
    runOne(14'h3FFF, mk(1'b1, 1'b0, 0, 0, 13 + LX));

    // Back-pressure: result must hold and a new input must not be taken
    applyStimulus(14'd3072, mk(1'b0, 1'b0, 11, 150, 2 + LX));
    waitResult();
    checkOutput();
    snapExp = out_exp;
    snapFrac = out_frac;
    stable = 1'b1;
    lin = 14'd5;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_exp === snapExp && out_frac === snapFrac))
        stable = 1'b0;
    end
    compare("bpStable", stable, 1);
    in_valid = 1'b0;
    consume();
    repeat (3) @(negedge clk);
    compare("bpNoTake", out_valid, 0);
    compare("holdExp", out_exp, 11);
    compare("holdFrac", out_frac, 150);

    cenDiv = 3;
    runOne(14'h0001, mk(1'b0, 1'b0, 0, 0, 13 + LX));
    runOne(14'h2000, mk(1'b1, 1'b0, 13, 0, LX));
    runOne(14'h0000, mk(1'b0, 1'b1, 0, 0, 1));
    cenDiv = 1;

    // Reset in the middle of normalisation discards the pending result
    runOne(14'h1FFF, mk(1'b0, 1'b0, 12, FRAC1FFF, 1 + LX));
    applyStimulus(14'h0001, mk(1'b0, 1'b0, 0, 0, 13 + LX));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    compare("midRstInReady", in_ready, 1);
    compare("midRstOutValid", out_valid, 0);
    compare("midRstOutExp", out_exp, 0);
    compare("midRstOutFrac", out_frac, 0);
    compare("midRstOutSign", out_sign, 0);
    compare("midRstOutZero", out_zero, 0);
    repeat (20) @(negedge clk);
    compare("midRstNoResult", out_valid, 0);
    runOne(14'd3072, mk(1'b0, 1'b0, 11, 150, 2 + LX));

    for (int b = 0; b < 13; b++) begin
      v = 14'(1 << b);
      runOne(v, refModel(v));
      v = 14'((2 << b) - 1);
      runOne(v, refModel(v));
      v = 14'(-(1 << b));
      runOne(v, refModel(v));
    end
    for (int k = 0; k < 350; k++) begin
      v = 14'($urandom);
      runOne(v, refModel(v));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
